rs232_recv: RTL

RS232_RECV -- requirements
Module: rs232_recv

---
 rtl/rs232_recv.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/rs232_recv.sv
// rs232_recv: 8N1 asynchronous serial receiver.
//
// Oversamples I_Rxd with the system clock. The start bit is confirmed at its
// mid-point. Data bits are then sampled one bit period apart, LSB first. The
// stop bit is checked at its mid-point, and the FSM goes back to idle there so
// that a start bit directly after the stop bit is still caught.
//
// Ports
//   I_Clk       : clock, rising edge
//   I_Rst_N     : asynchronous active-low reset (release synchronised by parent)
//   I_Rxd       : serial line, idle high, asynchronous to I_Clk
//   O_Data      : last correctly framed byte, held until the next good frame
//   O_Valid     : one-cycle pulse, O_Data has just been updated
//   O_Frame_Err : one-cycle pulse, the stop bit was sampled low
//   O_Busy      : high while a frame is being received (FSM not idle)
module rs232_recv #(
  parameter int unsigned P_CLK_FREQ  = 50000000,
  parameter int unsigned P_RS232_BPS = 115200
) (
  input  logic       I_Clk,
  input  logic       I_Rst_N,
  input  logic       I_Rxd,
  output logic [7:0] O_Data,
  output logic       O_Valid,
  output logic       O_Frame_Err,
  output logic       O_Busy
);

  localparam int unsigned P_BPS_Cnt = P_CLK_FREQ / P_RS232_BPS;
  localparam int unsigned P_MID     = P_BPS_Cnt / 2;

  localparam logic [15:0] LastCnt = 16'(P_BPS_Cnt - 1);
  localparam logic [15:0] MidCnt  = 16'(P_MID);

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic        valid_d, ferr_d;

  // Two synchroniser flops plus one delay flop for falling-edge detection.
  logic rxd_s1_q, rxd_s2_q, rxd_s3_q;
  logic rxd_sync;
  logic start_det;

  assign rxd_sync  = rxd_s2_q;
  assign start_det = rxd_s3_q & ~rxd_s2_q;

  always_ff @(posedge I_Clk or negedge I_Rst_N) begin
    if (!I_Rst_N) begin
      rxd_s1_q <= 1'b1;
      rxd_s2_q <= 1'b1;
      rxd_s3_q <= 1'b1;
    end else begin
      rxd_s1_q <= I_Rxd;
      rxd_s2_q <= rxd_s1_q;
      rxd_s3_q <= rxd_s2_q;
    end
  end

  always_ff @(posedge I_Clk or negedge I_Rst_N) begin
    if (!I_Rst_N) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    valid_d   = 1'b0;
    ferr_d    = 1'b0;

    case (state_q)
      StIdle: begin
        cnt_d     = '0;
        bit_idx_d = '0;
        if (start_det) begin
          state_d = StStart;
        end
      end

      StStart: begin
        if (cnt_q == MidCnt) begin
          cnt_d = '0;
          // A line already back high at mid start bit was only a glitch.
          state_d = rxd_sync ? StIdle : StData;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      StData: begin
        if (cnt_q == LastCnt) begin
          cnt_d     = '0;
          shift_d   = {rxd_sync, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
            state_d = StStop;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      StStop: begin
        if (cnt_q == LastCnt) begin
          cnt_d   = '0;
          valid_d = rxd_sync;
          ferr_d  = ~rxd_sync;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge I_Clk or negedge I_Rst_N) begin
    if (!I_Rst_N) begin
      O_Data      <= 8'h00;
      O_Valid     <= 1'b0;
      O_Frame_Err <= 1'b0;
    end else begin
      O_Valid     <= valid_d;
      O_Frame_Err <= ferr_d;
      if (valid_d) begin
        O_Data <= shift_q;
      end
    end
  end

  assign O_Busy = (state_q != StIdle);

endmodule
